// File: rtl/rca_lsq_port_arbiter.sv
// Round-robin arbiter sharing the single LSQ request port between NUM_REQ operational units.
// An in-order tag FIFO records who issued each load so completions are routed back to their owner.
module rca_lsq_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int XLEN            = 32,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*XLEN-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  input  logic [NUM_REQ*3-1:0]      req_fn3,
  input  logic [NUM_REQ-1:0]        req_load,
  input  logic [NUM_REQ-1:0]        req_store,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [XLEN-1:0]           resp_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [XLEN-1:0]           lsq_addr,
  output logic [XLEN-1:0]           lsq_data,
  output logic [2:0]                lsq_fn3,
  output logic                      lsq_load,
  output logic                      lsq_store,
  output logic                      lsq_new_request,
  input  logic                      lsq_full,
  input  logic [XLEN-1:0]           lsq_load_data,
  input  logic                      lsq_load_complete,
  output logic [CNT_W-1:0]          outstanding_loads,
  output logic                      protocol_error
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               err_q;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic               push;
  logic               pop;
  logic               fifo_has_room;

  assign fifo_has_room = (count < CNT_W'(MAX_OUTSTANDING));

  // A pop in this cycle does not count toward room: room is judged on the registered count.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && !lsq_full && (!req_load[i] || fifo_has_room);
    end
  end

  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
    if (rst) grant_found = 1'b0;
  end

  always_comb begin
    req_grant       = '0;
    lsq_new_request = 1'b0;
    lsq_addr        = '0;
    lsq_data        = '0;
    lsq_fn3         = '0;
    lsq_load        = 1'b0;
    lsq_store       = 1'b0;
    if (grant_found) begin
      req_grant[grant_idx] = 1'b1;
      lsq_new_request      = 1'b1;
      lsq_addr             = req_addr[grant_idx*XLEN +: XLEN];
      lsq_data             = req_data[grant_idx*XLEN +: XLEN];
      lsq_fn3              = req_fn3[grant_idx*3 +: 3];
      lsq_load             = req_load[grant_idx];
      lsq_store            = req_store[grant_idx];
    end
  end

  assign push = grant_found && req_load[grant_idx];
  assign pop  = !rst && lsq_load_complete && (count != '0);

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (pop) begin
      resp_valid[tag_mem[rd_ptr]] = 1'b1;
      resp_data                   = lsq_load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant_found) begin
        rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
      end
      if (push) begin
        tag_mem[wr_ptr] <= grant_idx;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (lsq_load_complete && count == '0) err_q <= 1'b1;
    end
  end

  assign outstanding_loads = count;
  assign protocol_error    = err_q;

endmodule

// File: tb/tb_rca_lsq_port_arbiter.sv
// Directed-vector bench for rca_lsq_port_arbiter: arbitration order, backpressure,
// load response routing, tag FIFO full/wrap behaviour and the sticky protocol error.
module tb_rca_lsq_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int XLEN    = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*XLEN-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ*3-1:0]    req_fn3;
  logic [NUM_REQ-1:0]      req_load;
  logic [NUM_REQ-1:0]      req_store;
  logic [NUM_REQ-1:0]      req_grant;
  logic [XLEN-1:0]         resp_data;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [XLEN-1:0]         lsq_addr;
  logic [XLEN-1:0]         lsq_data;
  logic [2:0]              lsq_fn3;
  logic                    lsq_load;
  logic                    lsq_store;
  logic                    lsq_new_request;
  logic                    lsq_full;
  logic [XLEN-1:0]         lsq_load_data;
  logic                    lsq_load_complete;
  logic [2:0]              outstanding_loads;
  logic                    protocol_error;

  int n_vec = 0;
  int n_err = 0;

  rca_lsq_port_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_fn3(req_fn3), .req_load(req_load), .req_store(req_store),
    .req_grant(req_grant), .resp_data(resp_data), .resp_valid(resp_valid),
    .lsq_addr(lsq_addr), .lsq_data(lsq_data), .lsq_fn3(lsq_fn3),
    .lsq_load(lsq_load), .lsq_store(lsq_store), .lsq_new_request(lsq_new_request),
    .lsq_full(lsq_full), .lsq_load_data(lsq_load_data),
    .lsq_load_complete(lsq_load_complete),
    .outstanding_loads(outstanding_loads), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_load  = '0;
    req_store = '0;
    req_addr  = '0;
    req_data  = '0;
    req_fn3   = '0;
  endtask

  task automatic set_req(input int i, input logic ld, input logic st, input logic [31:0] a);
    req_valid[i]           = 1'b1;
    req_load[i]            = ld;
    req_store[i]           = st;
    req_addr[i*XLEN +: XLEN] = a;
    req_data[i*XLEN +: XLEN] = a ^ 32'h5A5A_0000;
    req_fn3[i*3 +: 3]      = 3'(i + 1);
  endtask

  initial begin
    clear_reqs();
    rst               = 1'b1;
    lsq_full          = 1'b0;
    lsq_load_data     = '0;
    lsq_load_complete = 1'b0;

    // Requests while in reset must not be granted
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b1, 32'h100 + 32'(i));
    step(); step();
    settle();
    check("rst_grant", 64'(req_grant), 64'h0);
    check("rst_newreq", 64'(lsq_new_request), 64'h0);
    clear_reqs();
    step();
    rst = 1'b0;
    settle();
    check("dflt_grant", 64'(req_grant), 64'h0);
    check("dflt_resp_valid", 64'(resp_valid), 64'h0);
    check("dflt_resp_data", 64'(resp_data), 64'h0);
    check("dflt_newreq", 64'(lsq_new_request), 64'h0);
    check("dflt_addr", 64'(lsq_addr), 64'h0);
    check("dflt_outst", 64'(outstanding_loads), 64'h0);
    check("dflt_perr", 64'(protocol_error), 64'h0);

    // Round robin among four continuous stores: 0,1,2,3,0,1
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b1, 32'h100 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      settle();
      check("rr_grant", 64'(req_grant), 64'(4'b0001 << (c % 4)));
      check("rr_addr", 64'(lsq_addr), 64'h100 + 64'(c % 4));
      check("rr_data", 64'(lsq_data), 64'((32'h100 + 32'(c % 4)) ^ 32'h5A5A_0000));
      check("rr_fn3", 64'(lsq_fn3), 64'((c % 4) + 1));
      check("rr_store", 64'({lsq_new_request, lsq_load, lsq_store}), 64'b101);
      step();
    end

    // Backpressure: no grant while full, then requester at rr_ptr (2)
    lsq_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("bp_grant", 64'(req_grant), 64'h0);
      check("bp_newreq", 64'(lsq_new_request), 64'h0);
      step();
    end
    lsq_full = 1'b0;
    settle();
    check("bp_release", 64'(req_grant), 64'b0100);
    step();
    clear_reqs();

    // Loads from 2, 0, 3 (rr_ptr is now 3)
    set_req(2, 1'b1, 1'b0, 32'h2000);
    settle();
    check("ld2_grant", 64'(req_grant), 64'b0100);
    check("ld2_load", 64'(lsq_load), 64'h1);
    step();
    clear_reqs();
    check("ld_outst1", 64'(outstanding_loads), 64'h1);
    set_req(0, 1'b1, 1'b0, 32'h2100);
    settle();
    check("ld0_grant", 64'(req_grant), 64'b0001);
    step();
    clear_reqs();
    set_req(3, 1'b1, 1'b1, 32'h2300);
    settle();
    check("ld3_grant", 64'(req_grant), 64'b1000);
    check("ld3_ldst", 64'({lsq_load, lsq_store}), 64'b11);
    step();
    clear_reqs();
    check("ld_outst3", 64'(outstanding_loads), 64'h3);

    lsq_load_complete = 1'b1;
    lsq_load_data = 32'hA;
    settle();
    check("cpl_a_valid", 64'(resp_valid), 64'b0100);
    check("cpl_a_data", 64'(resp_data), 64'hA);
    step();
    lsq_load_data = 32'hB;
    settle();
    check("cpl_b_valid", 64'(resp_valid), 64'b0001);
    check("cpl_b_data", 64'(resp_data), 64'hB);
    step();
    lsq_load_data = 32'hC;
    settle();
    check("cpl_c_valid", 64'(resp_valid), 64'b1000);
    check("cpl_c_data", 64'(resp_data), 64'hC);
    step();
    lsq_load_complete = 1'b0;
    settle();
    check("cpl_outst0", 64'(outstanding_loads), 64'h0);
    check("cpl_idle_valid", 64'(resp_valid), 64'h0);
    check("cpl_perr", 64'(protocol_error), 64'h0);

    // Fill the tag FIFO with four loads from requester 0
    set_req(0, 1'b1, 1'b0, 32'h3000);
    for (int c = 0; c < 4; c++) begin
      settle();
      check("fill_grant", 64'(req_grant), 64'b0001);
      step();
    end
    clear_reqs();
    check("fill_outst4", 64'(outstanding_loads), 64'h4);
    set_req(1, 1'b1, 1'b0, 32'h3100);
    set_req(2, 1'b0, 1'b1, 32'h3200);
    settle();
    check("full_store_ok", 64'(req_grant), 64'b0100);
    step();
    clear_reqs();
    // Pop in same cycle does not free room for this cycle's load
    set_req(1, 1'b1, 1'b0, 32'h3100);
    lsq_load_complete = 1'b1;
    lsq_load_data = 32'hD;
    settle();
    check("full_pop_nogrant", 64'(req_grant), 64'h0);
    check("full_pop_valid", 64'(resp_valid), 64'b0001);
    step();
    lsq_load_complete = 1'b0;
    settle();
    check("full_outst3", 64'(outstanding_loads), 64'h3);
    check("full_ld1_grant", 64'(req_grant), 64'b0010);
    step();
    clear_reqs();
    check("full_outst4b", 64'(outstanding_loads), 64'h4);

    // Drain two (both tag 0), leaving tags {0,1}
    lsq_load_complete = 1'b1;
    lsq_load_data = 32'hE;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("drain_valid", 64'(resp_valid), 64'b0001);
      step();
    end
    lsq_load_complete = 1'b0;
    settle();
    check("drain_outst2", 64'(outstanding_loads), 64'h2);

    // Simultaneous push (req 3) and pop (tag 0) at count 2
    set_req(3, 1'b1, 1'b0, 32'h3300);
    lsq_load_complete = 1'b1;
    lsq_load_data = 32'hF0;
    settle();
    check("pp_grant", 64'(req_grant), 64'b1000);
    check("pp_valid", 64'(resp_valid), 64'b0001);
    check("pp_data", 64'(resp_data), 64'hF0);
    step();
    clear_reqs();
    settle();
    check("pp_outst2", 64'(outstanding_loads), 64'h2);
    lsq_load_data = 32'hF1;
    check("pp_next_valid", 64'(resp_valid), 64'b0010);
    step();
    lsq_load_data = 32'hF2;
    settle();
    check("pp_last_valid", 64'(resp_valid), 64'b1000);
    check("pp_last_data", 64'(resp_data), 64'hF2);
    step();

    // Spurious completion with empty FIFO
    settle();
    check("sp_outst0", 64'(outstanding_loads), 64'h0);
    check("sp_valid", 64'(resp_valid), 64'h0);
    check("sp_perr_pre", 64'(protocol_error), 64'h0);
    step();
    lsq_load_complete = 1'b0;
    settle();
    check("sp_perr_set", 64'(protocol_error), 64'h1);
    check("sp_outst_hold", 64'(outstanding_loads), 64'h0);
    step(); step();
    check("sp_perr_sticky", 64'(protocol_error), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("sp_perr_clr", 64'(protocol_error), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
